lpc_host: RTL and testbench

LPC bus initiator that issues single-byte I/O read and I/O write cycles toward an `lpc_dev` target and returns the target's response. It is the host end of the same LAD[3:0]/LFRAME# protocol `lpc_dev` decodes. It sits in the bench and in host-side bring-up designs, between a simple request/response port and the shared LPC pins. Pin tristating is left to the top level via `lad_oe`.

---
 rtl/lpc_pkg.sv | 39 +++
 rtl/lpc_sync_timer.sv | 38 +++
 rtl/lpc_host.sv | 232 +++++++++++++++++++++++
 tb/tb_lpc_host.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_pkg.sv
// Shared LPC host definitions: FSM state encoding, cycle-type, START and SYNC codes.
// ST_ABORT only exists when LPC_HOST_TIMEOUT_EN is defined.
package lpc_pkg;

   typedef enum logic [4:0] {
      ST_IDLE,
      ST_START,
      ST_CYCDIR,
      ST_ADDR0,
      ST_ADDR1,
      ST_ADDR2,
      ST_ADDR3,
      ST_WDATA0,
      ST_WDATA1,
      ST_TARH0,
      ST_TARH1,
      ST_SYNC,
      ST_RDATA0,
      ST_RDATA1,
      ST_TART0,
      ST_TART1,
      ST_DONE
`ifdef LPC_HOST_TIMEOUT_EN
      , ST_ABORT
`endif
   } lpc_state_e;

   localparam logic [3:0] CYC_IO_RD       = 4'h0;
   localparam logic [3:0] CYC_IO_WR       = 4'h2;
   localparam logic [3:0] START_CODE      = 4'h0;

   localparam logic [3:0] SYNC_READY      = 4'h0;
   localparam logic [3:0] SYNC_SHORT_WAIT = 4'h5;
   localparam logic [3:0] SYNC_LONG_WAIT  = 4'h6;
   localparam logic [3:0] SYNC_ERROR      = 4'hA;

   localparam int unsigned ABORT_LEN      = 4;

endpackage

// File: rtl/lpc_sync_timer.sv
// SYNC wait counter: cleared on SYNC entry, counts wait clocks, flags the clock
// that reaches SYNC_TIMEOUT. Used only when LPC_HOST_TIMEOUT_EN is defined.
module lpc_sync_timer #(
   parameter int unsigned SYNC_TIMEOUT = 32
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic last_o
);

   localparam int unsigned   CW   = (SYNC_TIMEOUT > 1) ? $clog2(SYNC_TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(SYNC_TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !last_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds the number of wait clocks already spent, so LAST marks the final one.
   assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/lpc_host.sv
// LPC host: issues single-byte I/O read/write cycles on LAD/LFRAME# and returns the
// target response. Define LPC_HOST_TIMEOUT_EN to enable the SYNC timeout and ABORT.
//
// state   | meaning
// IDLE    | accepting a request, LAD released
// START   | LFRAME# low, START code
// CYCDIR  | cycle type / direction nibble
// ADDR0-3 | I/O address, most significant nibble first
// WDATA0-1| write data, low nibble first
// TARH0-1 | host turnaround: drive 4'hF, then release
// SYNC    | wait for target sync code
// RDATA0-1| capture read data, low nibble first
// TART0-1 | target turnaround
// DONE    | rsp_valid pulse
// ABORT   | LFRAME# low with LAD 4'hF (timeout build only)
module lpc_host
   import lpc_pkg::*;
#(
   parameter int unsigned SYNC_TIMEOUT = 32
) (
   input  logic        LPC_CLK,
   input  logic        LPC_RST,
   output logic [3:0]  lad_out,
   output logic        lad_oe,
   input  logic [3:0]  lad_in,
   output logic        lframe_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err
);

   lpc_state_e  state_q, state_d;
   logic        write_q, write_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        sync_wait;

`ifdef LPC_HOST_TIMEOUT_EN
   localparam logic [1:0] ABORT_LAST = 2'(ABORT_LEN - 1);

   logic       tmr_clr, tmr_en, tmr_last;
   logic [1:0] abort_q, abort_d;

   lpc_sync_timer #(
      .SYNC_TIMEOUT (SYNC_TIMEOUT)
   ) u_sync_timer (
      .clk_i  (LPC_CLK),
      .rst_ni (LPC_RST),
      .clr_i  (tmr_clr),
      .en_i   (tmr_en),
      .last_o (tmr_last)
   );

   always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
      if (!LPC_RST) begin
         abort_q <= '0;
      end else begin
         abort_q <= abort_d;
      end
   end
`else
   // Timeout settings have no effect in this build.
   logic unused_cfg;
   assign unused_cfg = ^{SYNC_TIMEOUT, ABORT_LEN};
`endif

   // Unknown sync codes are treated as wait so a misbehaving target only stalls.
   always_comb begin
      sync_wait = 1'b1;
      case (lad_in)
         SYNC_READY, SYNC_ERROR:          sync_wait = 1'b0;
         SYNC_SHORT_WAIT, SYNC_LONG_WAIT: sync_wait = 1'b1;
         default:                         sync_wait = 1'b1;
      endcase
   end

   always_ff @(posedge LPC_CLK or negedge LPC_RST) begin
      if (!LPC_RST) begin
         state_q <= ST_IDLE;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      write_d   = write_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      lad_out   = 4'hF;
      lad_oe    = 1'b1;
      lframe_n  = 1'b1;
      rsp_valid = 1'b0;
`ifdef LPC_HOST_TIMEOUT_EN
      tmr_clr   = 1'b0;
      tmr_en    = 1'b0;
      abort_d   = abort_q;
`endif
      case (state_q)
         ST_IDLE: begin
            lad_oe = 1'b0;
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = 1'b0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            lframe_n = 1'b0;
            lad_out  = START_CODE;
            state_d  = ST_CYCDIR;
         end
         ST_CYCDIR: begin
            lad_out = write_q ? CYC_IO_WR : CYC_IO_RD;
            state_d = ST_ADDR0;
         end
         ST_ADDR0: begin
            lad_out = addr_q[15:12];
            state_d = ST_ADDR1;
         end
         ST_ADDR1: begin
            lad_out = addr_q[11:8];
            state_d = ST_ADDR2;
         end
         ST_ADDR2: begin
            lad_out = addr_q[7:4];
            state_d = ST_ADDR3;
         end
         ST_ADDR3: begin
            lad_out = addr_q[3:0];
            state_d = write_q ? ST_WDATA0 : ST_TARH0;
         end
         ST_WDATA0: begin
            lad_out = wdata_q[3:0];
            state_d = ST_WDATA1;
         end
         ST_WDATA1: begin
            lad_out = wdata_q[7:4];
            state_d = ST_TARH0;
         end
         ST_TARH0: begin
            lad_out = 4'hF;
            state_d = ST_TARH1;
         end
         ST_TARH1: begin
            lad_oe  = 1'b0;
`ifdef LPC_HOST_TIMEOUT_EN
            tmr_clr = 1'b1;
`endif
            state_d = ST_SYNC;
         end
         ST_SYNC: begin
            lad_oe = 1'b0;
            if (!sync_wait) begin
               err_d   = (lad_in == SYNC_ERROR);
               state_d = write_q ? ST_TART0 : ST_RDATA0;
            end
`ifdef LPC_HOST_TIMEOUT_EN
            else if (tmr_last) begin
               abort_d = '0;
               state_d = ST_ABORT;
            end
            tmr_en = sync_wait;
`endif
         end
         ST_RDATA0: begin
            lad_oe       = 1'b0;
            rdata_d[3:0] = lad_in;
            state_d      = ST_RDATA1;
         end
         ST_RDATA1: begin
            lad_oe       = 1'b0;
            rdata_d[7:4] = lad_in;
            state_d      = ST_TART0;
         end
         ST_TART0: begin
            lad_oe  = 1'b0;
            state_d = ST_TART1;
         end
         ST_TART1: begin
            lad_oe  = 1'b0;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            lad_oe    = 1'b0;
            rsp_valid = 1'b1;
            state_d   = ST_IDLE;
         end
`ifdef LPC_HOST_TIMEOUT_EN
         ST_ABORT: begin
            lframe_n = 1'b0;
            lad_out  = 4'hF;
            abort_d  = abort_q + 1'b1;
            if (abort_q == ABORT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end
         end
`endif
         default: begin
            lad_oe  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_lpc_host.sv
// Self-checking bench for lpc_host: the bench plays the LPC target and predicts every
// clock of each frame from the protocol rules. Timeout cases run with LPC_HOST_TIMEOUT_EN.
module tb_lpc_host;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b1;
   logic [3:0]  lad_out;
   logic        lad_oe;
   logic [3:0]  lad_in    = 4'hF;
   logic        lframe_n;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_addr  = 16'h0;
   logic [7:0]  req_wdata = 8'h0;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cyc = 0;
   int done_cyc = 0;
   logic [7:0] model_rdata = 8'h00;

   localparam int TMO = 8;

   typedef struct {
      logic       oe;
      logic [3:0] nib;
      logic       fr;
      logic [3:0] drv;
      logic       done;
      string      nm;
   } step_t;

   lpc_host #(.SYNC_TIMEOUT(TMO)) dut (
      .LPC_CLK   (clk),
      .LPC_RST   (rst_n),
      .lad_out   (lad_out),
      .lad_oe    (lad_oe),
      .lad_in    (lad_in),
      .lframe_n  (lframe_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic step_t mk(input logic oe, input logic [3:0] nib, input logic fr,
                                input logic [3:0] drv, input logic done, input string nm);
      step_t s;
      s.oe = oe; s.nib = nib; s.fr = fr; s.drv = drv; s.done = done; s.nm = nm;
      return s;
   endfunction

   // wcode == 0 picks a random non-terminal sync code for each wait clock.
   task automatic run_frame(input logic wr, input logic [15:0] a, input logic [7:0] wd,
                            input logic [7:0] rd, input int nwait, input logic [3:0] wcode,
                            input logic [3:0] term, input logic hold, input logic silent);
      step_t      q[$];
      logic [3:0] w;
      logic       exp_err;
      int         exp_len;
      q.push_back(mk(1'b1, 4'h0, 1'b0, 4'hF, 1'b0, "start"));
      q.push_back(mk(1'b1, wr ? 4'h2 : 4'h0, 1'b1, 4'hF, 1'b0, "cycdir"));
      for (int k = 3; k >= 0; k--) q.push_back(mk(1'b1, a[k*4 +: 4], 1'b1, 4'hF, 1'b0, "addr"));
      if (wr) begin
         q.push_back(mk(1'b1, wd[3:0], 1'b1, 4'hF, 1'b0, "wdata0"));
         q.push_back(mk(1'b1, wd[7:4], 1'b1, 4'hF, 1'b0, "wdata1"));
      end
      q.push_back(mk(1'b1, 4'hF, 1'b1, 4'hF, 1'b0, "tarh0"));
      q.push_back(mk(1'b0, 4'hF, 1'b1, 4'hF, 1'b0, "tarh1"));
      if (silent) begin
         for (int k = 0; k < TMO; k++) q.push_back(mk(1'b0, 4'hF, 1'b1, 4'hF, 1'b0, "sync_silent"));
         for (int k = 0; k < 4; k++) q.push_back(mk(1'b1, 4'hF, 1'b0, 4'hF, 1'b0, "abort"));
         exp_err = 1'b1;
         exp_len = (wr ? 10 : 8) + TMO + 4;
      end else begin
         for (int k = 0; k < nwait; k++) begin
            w = wcode;
            if (w == 4'h0) begin
               w = 4'($urandom_range(15));
               if (w == 4'h0 || w == 4'hA) w = 4'h5;
            end
            q.push_back(mk(1'b0, 4'hF, 1'b1, w, 1'b0, "sync_wait"));
         end
         q.push_back(mk(1'b0, 4'hF, 1'b1, term, 1'b0, "sync"));
         if (!wr) begin
            q.push_back(mk(1'b0, 4'hF, 1'b1, rd[3:0], 1'b0, "rdata0"));
            q.push_back(mk(1'b0, 4'hF, 1'b1, rd[7:4], 1'b0, "rdata1"));
            model_rdata = rd;
         end
         q.push_back(mk(1'b0, 4'hF, 1'b1, 4'hF, 1'b0, "tart0"));
         q.push_back(mk(1'b0, 4'hF, 1'b1, 4'hF, 1'b0, "tart1"));
         exp_err = (term == 4'hA);
         exp_len = 13 + nwait;
      end
      q.push_back(mk(1'b0, 4'hF, 1'b1, 4'hF, 1'b1, "done"));

      @(negedge clk);
      chk("req_ready_idle", 16'(req_ready), 16'h1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      foreach (q[i]) begin
         @(negedge clk);
         if (!hold) req_valid = 1'b0;
         lad_in = q[i].drv;
         if (i == 0) start_cyc = cyc;
         chk({q[i].nm, "_lframe_n"}, 16'(lframe_n), 16'(q[i].fr));
         chk({q[i].nm, "_lad_oe"}, 16'(lad_oe), 16'(q[i].oe));
         if (q[i].oe) chk({q[i].nm, "_lad_out"}, 16'(lad_out), 16'(q[i].nib));
         chk({q[i].nm, "_rsp_valid"}, 16'(rsp_valid), 16'(q[i].done));
         chk({q[i].nm, "_req_ready"}, 16'(req_ready), 16'h0);
         if (q[i].done) begin
            done_cyc = cyc;
            chk("rsp_err", 16'(rsp_err), 16'(exp_err));
            chk("rsp_rdata", 16'(rsp_rdata), 16'(model_rdata));
            chk("frame_length", 16'(done_cyc - start_cyc), 16'(exp_len));
         end
      end
      lad_in = 4'hF;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] a;
      logic [7:0]  wd, rd;
      logic        wr;
      int          d1;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_lframe_n", 16'(lframe_n), 16'h1);
      chk("rst_lad_oe", 16'(lad_oe), 16'h0);
      chk("rst_lad_out", 16'(lad_out), 16'hF);
      chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
      chk("rst_rsp_rdata", 16'(rsp_rdata), 16'h0);
      chk("rst_rsp_err", 16'(rsp_err), 16'h0);
      chk("rst_req_ready", 16'(req_ready), 16'h1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Directed: zero-wait write, read with two short waits, read with error sync.
      run_frame(1'b1, 16'h03F8, 8'h41, 8'h00, 0, 4'h0, 4'h0, 1'b0, 1'b0);
      run_frame(1'b0, 16'h03FD, 8'h00, 8'h60, 2, 4'h5, 4'h0, 1'b0, 1'b0);
      chk("read_rsp_clock", 16'(done_cyc - start_cyc + 1), 16'd16);
      run_frame(1'b0, 16'h0080, 8'h00, 8'hFF, 1, 4'h6, 4'hA, 1'b0, 1'b0);
      run_frame(1'b1, 16'hFFFF, 8'h00, 8'h00, 1, 4'h3, 4'hA, 1'b0, 1'b0);

      for (int n = 0; n < 10; n++) begin
         wr = 1'($urandom_range(1));
         a  = 16'($urandom);
         wd = 8'($urandom);
         rd = 8'($urandom);
         run_frame(wr, a, wd, rd, int'($urandom_range(6)), 4'h0,
                   ($urandom_range(3) == 0) ? 4'hA : 4'h0, 1'b0, 1'b0);
      end

`ifdef LPC_HOST_TIMEOUT_EN
      run_frame(1'b0, 16'h1234, 8'h00, 8'h00, 0, 4'h0, 4'h0, 1'b0, 1'b1);
      run_frame(1'b1, 16'hBEEF, 8'hC3, 8'h00, 0, 4'h0, 4'h0, 1'b0, 1'b1);
      run_frame(1'b0, 16'h4321, 8'h00, 8'h5A, TMO - 1, 4'h0, 4'h0, 1'b0, 1'b0);
`endif

      // Reset in ADDR2: outputs drop without a clock edge and no response follows.
      a = 16'hA5C3;
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = a;
      repeat (5) begin
         @(negedge clk);
         req_valid = 1'b0;
      end
      chk("addr2_lad_out", 16'(lad_out), 16'(a[7:4]));
      #2 rst_n = 1'b0;
      #1;
      model_rdata = 8'h00;
      chk("midrst_lad_oe", 16'(lad_oe), 16'h0);
      chk("midrst_lframe_n", 16'(lframe_n), 16'h1);
      chk("midrst_lad_out", 16'(lad_out), 16'hF);
      chk("midrst_req_ready", 16'(req_ready), 16'h1);
      chk("midrst_rsp_rdata", 16'(rsp_rdata), 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("postrst_rsp_valid", 16'(rsp_valid), 16'h0);
         chk("postrst_lad_oe", 16'(lad_oe), 16'h0);
      end
      run_frame(1'b0, 16'h0060, 8'h00, 8'h9C, 0, 4'h0, 4'h0, 1'b0, 1'b0);

      // Back-to-back with req_valid held: IDLE for exactly one clock after DONE.
      run_frame(1'b1, 16'h0070, 8'h12, 8'h00, 0, 4'h0, 4'h0, 1'b1, 1'b0);
      d1 = done_cyc;
      run_frame(1'b0, 16'h0071, 8'h00, 8'h34, 1, 4'h0, 4'h0, 1'b0, 1'b0);
      chk("b2b_start_gap", 16'(start_cyc - d1), 16'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
